lsu_mem_interface: RTL

- Load/store unit directly downstream of the immediate generator.
- Adds the sign-extended LOAD/STORE offset to the rs1 base to form the effective address, then runs one RV32I load or store against the data memory over a req/ack handshake.
- Lane-aligns store data with byte enables; extracts and sign/zero-extends load data.
- Flags misaligned or unsupported accesses without issuing a memory request.

---
 rtl/lsu_mem_interface.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_interface.sv
// RV32I load/store unit: forms the effective address, runs one data-memory access over a
// req/ack handshake, lane-aligns store data and extends load data.
`timescale 1ns / 1ps

module lsu_mem_interface #(
  parameter int unsigned RISC_V_DATA_WIDTH = 32,
  parameter int unsigned BYTES             = RISC_V_DATA_WIDTH / 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  // core side
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                is_store,
  input  logic [2:0]                          funct3,
  input  logic [RISC_V_DATA_WIDTH-1:0]        base_addr,
  input  logic signed [RISC_V_DATA_WIDTH-1:0] offset,
  input  logic [RISC_V_DATA_WIDTH-1:0]        store_data,
  // data memory side
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [RISC_V_DATA_WIDTH-1:0]        mem_addr,
  output logic [BYTES-1:0]                    mem_be,
  output logic [RISC_V_DATA_WIDTH-1:0]        mem_wdata,
  input  logic                                mem_ack,
  input  logic [RISC_V_DATA_WIDTH-1:0]        mem_rdata,
  // completion
  output logic                                done,
  output logic                                rd_valid,
  output logic [RISC_V_DATA_WIDTH-1:0]        rd_data,
  output logic                                misaligned
);

  localparam logic [BYTES-1:0] BeByte = BYTES'(1);
  localparam logic [BYTES-1:0] BeHalf = BYTES'(3);
  localparam logic [BYTES-1:0] BeWord = '1;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e state_q, state_d;

  logic                         is_store_q;
  logic [2:0]                   funct3_q;
  logic [1:0]                   ea_lo_q;
  logic                         err_q;
  logic [RISC_V_DATA_WIDTH-1:0] mem_addr_q;
  logic [BYTES-1:0]             mem_be_q;
  logic [RISC_V_DATA_WIDTH-1:0] mem_wdata_q;
  logic [RISC_V_DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [RISC_V_DATA_WIDTH-1:0] ea;
  logic                         legal;
  logic                         aligned;
  logic                         err;
  logic                         accept;
  logic [BYTES-1:0]             be_d;
  logic [RISC_V_DATA_WIDTH-1:0] wdata_d;
  logic [7:0]                   lane_byte;
  logic [15:0]                  lane_half;

  // Wrap-around of the address sum is architecturally legal.
  assign ea     = base_addr + offset;
  assign accept = (state_q == StIdle) && req_valid;
  assign err    = ~legal | ~aligned;

  // Decode width/sign and alignment of the incoming access.
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    case (funct3)
      3'b000: legal = 1'b1;
      3'b001: begin
        legal   = 1'b1;
        aligned = ~ea[0];
      end
      3'b010: begin
        legal   = 1'b1;
        aligned = (ea[1:0] == 2'b00);
      end
      3'b100: legal = ~is_store;
      3'b101: begin
        legal   = ~is_store;
        aligned = ~ea[0];
      end
      default: legal = 1'b0;
    endcase
  end

  // Byte enables and replicated write data so the addressed lane carries the value.
  always_comb begin
    be_d    = BeWord;
    wdata_d = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_d    = BeByte << ea[1:0];
        wdata_d = {BYTES{store_data[7:0]}};
      end
      2'b01: begin
        be_d    = BeHalf << ea[1:0];
        wdata_d = {(BYTES / 2){store_data[15:0]}};
      end
      default: begin
        be_d    = BeWord;
        wdata_d = store_data;
      end
    endcase
  end

  // Lane extraction and sign/zero extension of the returned word.
  always_comb begin
    lane_byte = mem_rdata[{ea_lo_q, 3'b000} +: 8];
    lane_half = mem_rdata[{ea_lo_q[1], 4'b0000} +: 16];
    case (funct3_q[1:0])
      2'b00:   rd_data_d = {{(RISC_V_DATA_WIDTH - 8){~funct3_q[2] & lane_byte[7]}}, lane_byte};
      2'b01:   rd_data_d = {{(RISC_V_DATA_WIDTH - 16){~funct3_q[2] & lane_half[15]}}, lane_half};
      default: rd_data_d = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) state_d = err ? StResp : StReq;
      end
      StReq: begin
        if (mem_ack) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      ea_lo_q     <= 2'b00;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_store_q  <= is_store;
        funct3_q    <= funct3;
        ea_lo_q     <= ea[1:0];
        err_q       <= err;
        mem_addr_q  <= {ea[RISC_V_DATA_WIDTH-1:2], 2'b00};
        mem_be_q    <= be_d;
        mem_wdata_q <= wdata_d;
      end
      if ((state_q == StReq) && mem_ack && !is_store_q) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  // Handshake and completion strobes decode straight from state, so reset drops them at once.
  assign req_ready  = (state_q == StIdle);
  assign mem_req    = (state_q == StReq);
  assign mem_we     = mem_req & is_store_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign done       = (state_q == StResp);
  assign misaligned = done & err_q;
  assign rd_valid   = done & ~err_q & ~is_store_q;
  assign rd_data    = rd_data_q;

endmodule
